// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RISC-V M-extension unit (shift-add multiplier and
//               radix-2 restoring divider). Optional macro MULDIV_FASTPATH_EN
//               lets trivial cases (x/0, MIN/-1, multiply by 0) bypass ITER.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_sequencer #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_rd,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_MULW   = 4'd4;
    localparam logic [3:0] OP_DIV    = 4'd5;
    localparam logic [3:0] OP_DIVU   = 4'd6;
    localparam logic [3:0] OP_REM    = 4'd7;
    localparam logic [3:0] OP_REMU   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    localparam logic [6:0] C_MUL_N  = 7'(XLEN / MUL_BITS);
    localparam logic [6:0] C_MUL_NW = 7'(32 / MUL_BITS);
    localparam logic [6:0] C_DIV_N  = 7'(XLEN);
    localparam logic [6:0] C_DIV_NW = 7'd32;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     rs1_q, rs1_d;
    logic [XLEN-1:0]     rs2_q, rs2_d;
    logic [TAG_W-1:0]    rd_q, rd_d;
    logic                neg_q, neg_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [TAG_W-1:0]    resp_rd_q, resp_rd_d;

    // Operation decode of the latched op
    logic w_is_mul, w_is_w, w_is_rem, w_sgn_a, w_sgn_b, w_sdiv;
    assign w_is_mul = (op_q <= OP_MULW);
    assign w_is_w   = (op_q == OP_MULW) || ((op_q >= OP_DIVW) && (op_q <= OP_REMUW));
    assign w_is_rem = (op_q inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW});
    assign w_sgn_a  = (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW});
    assign w_sgn_b  = (op_q inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW});
    assign w_sdiv   = (op_q inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW});

    logic [XLEN-1:0] w_ext_a, w_ext_b, w_mag_a, w_mag_b, w_min;
    logic            w_neg_a, w_neg_b, w_neg_res, w_div0, w_ovf, w_mul_zero;

    assign w_ext_a = w_is_w ? (w_sgn_a ? sext32(rs1_q[31:0]) : {{(XLEN-32){1'b0}}, rs1_q[31:0]}) : rs1_q;
    assign w_ext_b = w_is_w ? (w_sgn_b ? sext32(rs2_q[31:0]) : {{(XLEN-32){1'b0}}, rs2_q[31:0]}) : rs2_q;
    assign w_neg_a = w_sgn_a & w_ext_a[XLEN-1];
    assign w_neg_b = w_sgn_b & w_ext_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -w_ext_a : w_ext_a;
    assign w_mag_b = w_neg_b ? -w_ext_b : w_ext_b;
    // Remainders take the dividend sign; everything else signed takes a^b
    assign w_neg_res  = w_sgn_b ? (w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b)) : w_neg_a;
    assign w_min      = w_is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0     = !w_is_mul && (w_ext_b == '0);
    assign w_ovf      = w_sdiv && (w_ext_a == w_min) && (w_ext_b == '1);
    assign w_mul_zero = w_is_mul && ((w_ext_a == '0) || (w_ext_b == '0));

    // Multiplier step: accumulate multiplicand * next digit into the high half
    logic [XLEN+MUL_BITS-1:0] w_pp, w_mul_sum;
    logic [2*XLEN-1:0]        w_mul_next;
    assign w_pp       = {{MUL_BITS{1'b0}}, dvs_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
    assign w_mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + w_pp;
    assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:MUL_BITS]};

    // Divider step: acc holds {remainder, dividend/quotient}
    logic [2*XLEN:0]   w_div_sh;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    assign w_div_sh   = {acc_q, 1'b0};
    assign w_div_diff = w_div_sh[2*XLEN:XLEN] - {1'b0, dvs_q};
    assign w_div_next = w_div_diff[XLEN] ? w_div_sh[2*XLEN-1:0]
                                         : {w_div_diff[XLEN-1:0], w_div_sh[XLEN-1:1], 1'b1};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
    assign w_prod = neg_q ? -acc_q : acc_q;
    assign w_quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        case (op_q)
            OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_MULW:                      w_fix_res = sext32(acc_q[XLEN-1:XLEN-32]);
            OP_DIV, OP_DIVU:              w_fix_res = w_quo;
            OP_REM, OP_REMU:              w_fix_res = w_rem;
            OP_DIVW, OP_DIVUW:            w_fix_res = sext32(w_quo[31:0]);
            OP_REMW, OP_REMUW:            w_fix_res = sext32(w_rem[31:0]);
            default:                      w_fix_res = '0;
        endcase
        // Architectural special cases override whatever the datapath produced
        if (w_div0) begin
            if (w_is_rem) w_fix_res = w_is_w ? sext32(w_ext_a[31:0]) : w_ext_a;
            else          w_fix_res = '1;
        end else if (w_ovf) begin
            w_fix_res = w_is_rem ? '0 : w_min;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        resp_rd_d = resp_rd_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_d  = req_op;
                        rs1_d = req_rs1;
                        rs2_d = req_rs2;
                        rd_d  = req_rd;
                        if (req_op > OP_REMUW) begin
                            result_d  = '0;
                            resp_rd_d = req_rd;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    neg_d = w_neg_res;
                    dvs_d = w_mag_b;
                    if (w_is_mul) begin
                        cnt_d = w_is_w ? C_MUL_NW : C_MUL_N;
                        acc_d = {{XLEN{1'b0}}, w_mag_a};
                    end else begin
                        cnt_d = w_is_w ? C_DIV_NW : C_DIV_N;
                        // W dividends start in the upper word so 32 steps drain them
                        acc_d = {{XLEN{1'b0}}, (w_is_w ? (w_mag_a << 32) : w_mag_a)};
                    end
                    state_d = S_ITER;
`ifdef MULDIV_FASTPATH_EN
                    if (w_div0 || w_ovf || w_mul_zero) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
`endif
                end
                S_ITER: begin
                    if (cnt_q == 7'd0) begin
                        state_d = S_FIX;
                    end else begin
                        acc_d = w_is_mul ? w_mul_next : w_div_next;
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                S_FIX: begin
                    result_d  = w_fix_res;
                    resp_rd_d = rd_q;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            resp_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            resp_rd_q <= resp_rd_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign resp_result = result_q;
    assign resp_rd     = resp_rd_q;

    logic w_unused;
    assign w_unused = w_mul_zero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer with an
//               arithmetic reference model and a per-cycle output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_sequencer;

    localparam int MUL_BITS = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    logic        clk, reset, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
    logic [3:0]  req_op;
    logic [63:0] req_rs1, req_rs2, resp_result;
    logic [5:0]  req_rd, resp_rd;

    muldiv_sequencer #(.XLEN(64), .MUL_BITS(MUL_BITS), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_rd(resp_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          exp_lat = 0;
    bit          mon_en = 0;
    logic [63:0] exp_res = '0;
    logic [5:0]  exp_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M semantics in plain arithmetic
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        longint sa, sb;
        int sa32, sb32;
        logic [31:0] a32, b32;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        case (op)
            4'd0: return a * b;
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            4'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            4'd4: begin p = {64'b0, a} * {64'b0, b}; return sx(p[31:0]); end
            4'd5: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                return 64'(sa / sb);
            end
            4'd6: begin if (b == 0) return ONES; return a / b; end
            4'd7: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                return 64'(sa % sb);
            end
            4'd8: begin if (b == 0) return a; return a % b; end
            4'd9: begin
                if (b32 == 0) return ONES;
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(32'h8000_0000);
                return sx(32'(sa32 / sb32));
            end
            4'd10: begin if (b32 == 0) return ONES; return sx(a32 / b32); end
            4'd11: begin
                if (b32 == 0) return sx(a32);
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                return sx(32'(sa32 % sb32));
            end
            4'd12: begin if (b32 == 0) return sx(a32); return sx(a32 % b32); end
            default: return 64'd0;
        endcase
    endfunction

    // Clocks from the accept edge until resp_valid is first seen high
    function automatic int latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w;
        w = (op == 4'd4) || (op >= 4'd9 && op <= 4'd12);
        if (op >= 4'd13) return 0;
`ifdef MULDIV_FASTPATH_EN
        if (op <= 4'd4 && (w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0))) return 2;
        if (op > 4'd4 && (w ? (b[31:0] == 0) : (b == 0))) return 2;
        if ((op == 4'd5 || op == 4'd7) && a == MIN && b == ONES) return 2;
        if ((op == 4'd9 || op == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
`endif
        if (op <= 4'd4) return (w ? 32 : 64) / MUL_BITS + 3;
        return (w ? 32 : 64) + 3;
    endfunction

    // Per-cycle compare of the in-flight operation against the model
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {63'b0, busy}, 64'd1);
            check("req_ready", {63'b0, req_ready}, 64'd0);
            check("resp_valid", {63'b0, resp_valid}, (cyc >= exp_lat) ? 64'd1 : 64'd0);
            if (cyc >= exp_lat) begin
                check("resp_result", resp_result, exp_res);
                check("resp_rd", {58'b0, resp_rd}, {58'b0, exp_rd});
            end
        end
    end

    task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [5:0] rd);
        @(negedge clk);
        req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
        exp_res = model(op, a, b); exp_rd = rd; exp_lat = latency(op, a, b);
        @(posedge clk);
        cyc = 0; mon_en = 1;
        #1 req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] rd, input logic [63:0] lit, input int hold, input bit poke);
        start_op(op, a, b, rd);
        while (cyc < exp_lat + hold) begin
            @(posedge clk);
            cyc++;
            #1;
            if (poke && cyc >= exp_lat) begin
                req_valid = 1'b1; req_op = 4'd0; req_rs1 = 64'd3; req_rs2 = 64'd3; req_rd = 6'd63;
            end
        end
        @(negedge clk);
        check("literal", resp_result, lit);
        resp_ready = 1'b1;
        @(posedge clk);
        mon_en = 0;
        #1 resp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("idle_ready", {63'b0, req_ready}, 64'd1);
        check("idle_valid", {63'b0, resp_valid}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_ready"}, {63'b0, req_ready}, 64'd1);
        check({tag, "_valid"}, {63'b0, resp_valid}, 64'd0);
        check({tag, "_result"}, resp_result, 64'd0);
        check({tag, "_rd"}, {58'b0, resp_rd}, 64'd0);
    endtask

    initial begin
        bit seen;
        clk = 0; reset = 0; req_valid = 0; flush = 0; resp_ready = 0;
        req_op = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #2 check_reset_outputs("reset");
        @(negedge clk) reset = 0;

        run_op(4'd5,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'd5, 64'hFFFF_FFFF_FFFF_FFFA, 2, 0);
        run_op(4'd8,  64'd7, 64'd0, 6'd6, 64'd7, 1, 0);
        run_op(4'd6,  64'd7, 64'd0, 6'd7, ONES, 1, 0);
        run_op(4'd1,  MIN, 64'd2, 6'd8, ONES, 1, 0);
        run_op(4'd3,  MIN, 64'd2, 6'd9, 64'd1, 1, 0);
        run_op(4'd0,  MIN, 64'd2, 6'd10, 64'd0, 1, 0);
        run_op(4'd9,  64'hFFFF_FFFF_8000_0000, ONES, 6'd11, 64'hFFFF_FFFF_8000_0000, 1, 0);
        run_op(4'd11, 64'hFFFF_FFFF_8000_0000, ONES, 6'd12, 64'd0, 1, 0);

        // Flush in the middle of a divide: nothing may come out
        start_op(4'd5, 64'd100, 64'd7, 6'd30);
        while (cyc < 10) begin @(posedge clk); cyc++; end
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        mon_en = 0;
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_ready", {63'b0, req_ready}, 64'd1);
        seen = 0;
        repeat (80) @(negedge clk) if (resp_valid) seen = 1;
        check("flush_no_resp", {63'b0, seen}, 64'd0);
        run_op(4'd0, 64'd6, 64'd7, 6'd13, 64'd42, 1, 0);

        // Stall in DONE with a competing request that must be ignored
        run_op(4'd7,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd14, ONES, 5, 1);
        run_op(4'd2,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 6'd15, ONES, 0, 0);
        run_op(4'd4,  64'h7FFF_FFFF, 64'd2, 6'd16, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(4'd10, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 6'd17, 64'h0FFF_FFFF, 0, 0);
        run_op(4'd12, 64'h1_FFFF_FFFF, 64'd0, 6'd18, ONES, 0, 0);
        run_op(4'd5,  MIN, ONES, 6'd19, MIN, 0, 0);
        run_op(4'd7,  MIN, ONES, 6'd20, 64'd0, 0, 0);
        run_op(4'd0,  64'h1234_5678_9ABC_DEF0, 64'd3, 6'd21, 64'h369D_0369_D036_9CD0, 0, 0);
        run_op(4'd3,  ONES, ONES, 6'd22, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(4'd13, 64'd5, 64'd5, 6'd23, 64'd0, 1, 0);

        // Asynchronous reset pulse mid-ITER clears outputs before any clock edge
        start_op(4'd6, 64'd1000, 64'd3, 6'd40);
        while (cyc < 20) begin @(posedge clk); cyc++; end
        mon_en = 0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk) reset = 1'b0;
        run_op(4'd6, 64'd100, 64'd7, 6'd24, 64'd14, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
